// File: rtl/ed_sim_ddr4a_cal_bus_msg_capture.sv
// ed_sim_ddr4a_cal_bus_msg_capture: snoops cal-bus mailbox writes, unpacks NUL-terminated
// characters into a show-ahead FIFO for a core-side or debug consumer.
module ed_sim_ddr4a_cal_bus_msg_capture #(
  parameter logic [19:0] MSG_BASE_ADDR = 20'h1_0000,
  parameter int NUM_CHANNELS = 1,
  parameter int ADDR_STRIDE = 4,
  parameter int FIFO_DEPTH = 256,
  localparam int CH_W = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1,
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             cal_bus_clk,
  input  logic             cal_bus_reset_n,
  input  logic             cal_bus_avl_write,
  input  logic [19:0]      cal_bus_avl_address,
  input  logic [31:0]      cal_bus_avl_write_data,
  input  logic             capture_en,
  input  logic             clear,
  output logic             msg_valid,
  input  logic             msg_ready,
  output logic [7:0]       msg_char,
  output logic [CH_W-1:0]  msg_channel,
  output logic             msg_eom,
  output logic [LVL_W-1:0] fifo_level,
  output logic [15:0]      drop_count,
  output logic             busy
);
  localparam int PTR_W = LVL_W - 1;
  logic hit, cap, push, pop, done;
  logic [CH_W-1:0] hit_ch, act_ch, pend_ch;
  logic act_v, pend_v;
  logic [31:0] act_data, pend_data;
  logic [1:0] idx;
  logic [7:0] cur;
  logic [CH_W+8:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level;
  always_comb begin
    hit = 1'b0;
    hit_ch = '0;
    for (int c = 0; c < NUM_CHANNELS; c++)
      if (cal_bus_avl_address == 20'(MSG_BASE_ADDR + c * ADDR_STRIDE)) begin
        hit = 1'b1;
        hit_ch = CH_W'(c);
      end
  end
  assign cap = cal_bus_avl_write & capture_en & hit;
  assign cur = act_data[{idx, 3'b000} +: 8];
  assign push = act_v & (level != LVL_W'(FIFO_DEPTH));
  assign done = push & (cur == 8'd0 | idx == 2'd3);
  assign msg_valid = level != '0;
  assign pop = msg_valid & msg_ready;
  assign {msg_channel, msg_char, msg_eom} = msg_valid ? mem[rd_ptr] : '0;
  assign fifo_level = level;
  assign busy = act_v | pend_v;
  // Later assignments override the pending->active hand-off when a capture lands on the same edge.
  always_ff @(posedge cal_bus_clk or negedge cal_bus_reset_n) begin
    if (!cal_bus_reset_n) begin
      act_v <= 1'b0;
      pend_v <= 1'b0;
      act_ch <= '0;
      pend_ch <= '0;
      act_data <= '0;
      pend_data <= '0;
      idx <= '0;
      drop_count <= '0;
    end else if (clear) begin
      act_v <= 1'b0;
      pend_v <= 1'b0;
      idx <= '0;
      drop_count <= '0;
    end else begin
      if (done) begin
        idx <= '0;
        act_v <= pend_v;
        act_ch <= pend_ch;
        act_data <= pend_data;
        pend_v <= 1'b0;
      end else if (push) idx <= idx + 2'd1;
      if (cap & (!act_v | done) & !pend_v) begin
        act_v <= 1'b1;
        act_ch <= hit_ch;
        act_data <= cal_bus_avl_write_data;
        idx <= '0;
      end else if (cap & (!pend_v | done)) begin
        pend_v <= 1'b1;
        pend_ch <= hit_ch;
        pend_data <= cal_bus_avl_write_data;
      end else if (cap && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end
  always_ff @(posedge cal_bus_clk or negedge cal_bus_reset_n) begin
    if (!cal_bus_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + LVL_W'(push) - LVL_W'(pop);
    end
  end
  always_ff @(posedge cal_bus_clk)
    if (push & !clear) mem[wr_ptr] <= {act_ch, cur, cur == 8'd0};
endmodule

// File: doc/ed_sim_ddr4a_cal_bus_msg_capture.md
# ed_sim_ddr4a_cal_bus_msg_capture

Synthesizable, multi-channel capture of calibration-sequencer debug messages. The block snoops sequencer writes on the EMIF calibration bus, unpacks each 32-bit mailbox word into NUL-terminated character streams, and buffers the characters in a FIFO. A core-side or debug consumer drains the FIFO, so messages are observable in hardware and post-fit simulation, not only in RTL simulation. It sits beside the io_aux wrapper on the cal_bus_* signals and never drives that bus.

## Interface
Parameters:
- MSG_BASE_ADDR, 20'h1_0000: address of the channel 0 mailbox.
- NUM_CHANNELS, 1: number of mailboxes (1-4). Channel c is at MSG_BASE_ADDR + c*ADDR_STRIDE.
- ADDR_STRIDE, 4: address spacing between mailboxes.
- FIFO_DEPTH, 256: FIFO depth in entries. Must be a power of two, minimum 4.

Derived widths:
- CH_W = max(1, clog2(NUM_CHANNELS)).
- LVL_W = clog2(FIFO_DEPTH)+1.

Ports:
- cal_bus_clk  in  1  calibration bus clock; the only clock.
- cal_bus_reset_n  in  1  reset, asynchronous, active-low.
- cal_bus_avl_write  in  1  snooped write strobe.
- cal_bus_avl_address  in  20  snooped write address.
- cal_bus_avl_write_data  in  32  snooped write data; byte 0 = [7:0].
- capture_en  in  1  when high, matching writes are captured.
- clear  in  1  synchronous flush pulse.
- msg_valid  out  1  FIFO head entry valid.
- msg_ready  in  1  consumer accepts the head entry.
- msg_char  out  8  head character (0 when msg_eom).
- msg_channel  out  CH_W  head channel index.
- msg_eom  out  1  head entry is an end-of-message marker.
- fifo_level  out  LVL_W  occupied entries.
- drop_count  out  16  number of dropped words; saturates at 16'hFFFF.
- busy  out  1  the active or pending word register is occupied.

## Operation
**Capture**
- A capture occurs when all of the following hold: cal_bus_avl_write=1, capture_en=1, and cal_bus_avl_address equals a mailbox address.
- A capture latches {channel, data} into the active register if the active register is empty or finishes this cycle.
- Otherwise the capture goes into the pending register, if that is empty.
- Otherwise the word is dropped and drop_count increments (saturating).
- Non-matching addresses and reads are ignored.

**Unpacker**
- The unpacker holds a byte index idx (0-3). Each cycle the active register is occupied and the FIFO is not full, it examines byte[idx]:
  - byte != 0: push {ch, byte, eom=0}. If idx==3 the word is done; otherwise idx++.
  - byte == 0: push {ch, 8'h00, eom=1}. The word is done.
- When the word is done, pending moves to active (idx=0) on the same edge, if pending is valid.
- FIFO full: no push and no advance. The unpacker stalls, and no characters are lost.
- A word with no NUL byte produces 4 entries and no marker; the message continues in the next word on that channel.
- Words from different channels are interleaved per word. The consumer demultiplexes by msg_channel.

**FIFO and controls**
- The FIFO is show-ahead: msg_* presents the head entry whenever msg_valid=1.
- A pop occurs when msg_valid & msg_ready.
- A push is blocked when fifo_level==FIFO_DEPTH, even if a pop occurs in the same cycle.
- When a push and a pop occur in the same cycle, fifo_level is unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- clear empties the FIFO, active, and pending registers, and zeroes drop_count. clear has priority over a capture, push, or pop in the same cycle.
- capture_en=0 blocks new captures only; words already held continue to drain.

## Timing
- Reset (asynchronous assertion): every output is 0, the FIFO is empty, both word registers are empty, and drop_count=0. This applies mid-unpack too: the partial word is discarded.
- Write sampled at edge E with the unpacker idle and the FIFO not full:
  - byte 0 is pushed at edge E+1;
  - msg_valid=1 in the cycle after E+1;
  - byte k is pushed at edge E+1+k.
- Unpacker throughput is one entry per cycle; a 4-character word occupies the unpacker for 4 cycles.
- Two back-to-back captures are absorbed by active plus pending. A third capture within the same unpack window is dropped.
- busy falls in the cycle after the edge that pushes the last entry of the final held word.
- fifo_level, drop_count, and busy are registered outputs.

## Test plan
- **Single message:** write 32'h0000_6948 to 20'h1_0000.
  - Entries in order: 'H'(8'h48), 'i'(8'h69), eom(char 0).
  - fifo_level=3; msg_valid high in the cycle after E+1.
- **Message spanning two words:** write 32'h6C6C_6548, then 32'h0000_006F.
  - Entries: H, e, l, l, o, then eom.
  - No eom after the first word; drop_count=0.
- **Overflow of word registers:** three captures on consecutive cycles, each with 4 non-NUL bytes.
  - The third word is dropped; drop_count=1.
  - 8 entries total; busy deasserts after 8 pushes.
- **FIFO backpressure:** FIFO_DEPTH=8, msg_ready=0, write three 4-character words.
  - fifo_level=8; the unpacker stalls and busy=1.
  - Then set msg_ready=1: all 12 characters arrive in order, drop_count=0.
- **Multiple channels:** NUM_CHANNELS=2.
  - Write 32'h0000_4B4F to 20'h1_0004: 'O', 'K', eom, all with msg_channel=1.
  - A write to 20'h1_0008 is ignored.
  - capture_en=0 blocks a write to 20'h1_0000.
- **Reset and clear mid-operation:**
  - Assert cal_bus_reset_n=0 during an unpack: all outputs are 0 immediately.
  - Repeat with a clear pulse: the FIFO is empty and drop_count=0 after the edge.
  - A capture in the same cycle as clear is discarded.
